// File: rtl/spi_pkg.sv
// Shared types for the multi-mode SPI master: FSM states and the per-transfer mode bundle.
package spi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StShift,
    StHold
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_mode_t;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: ticks every div_i+1 cycles while running and toggles the SCLK level on
// ticks flagged by toggle_i, reporting whether each toggle is a leading or trailing edge.
module spi_clk_gen #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             aresetn_i,
  input  logic             start_i,
  input  logic             run_i,
  input  logic             toggle_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             cpol_i,
  output logic             tick_o,
  output logic             lead_stb_o,
  output logic             trail_stb_o,
  output logic             sclk_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;

  always_comb begin
    tick_o      = run_i && (cnt_q == div_i);
    // Leading edge moves SCLK away from its idle (CPOL) level.
    lead_stb_o  = tick_o && toggle_i && (sclk_q == cpol_i);
    trail_stb_o = tick_o && toggle_i && (sclk_q != cpol_i);
    cnt_d       = cnt_q;
    sclk_d      = sclk_q;
    if (start_i) begin
      cnt_d  = '0;
      sclk_d = cpol_i;
    end else if (!run_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = tick_o ? '0 : cnt_q + DIV_W'(1);
      if (tick_o && toggle_i) sclk_d = ~sclk_q;
    end
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;

endmodule

// File: rtl/spi_master_multi.sv
// SPI master with configurable word width, CPOL/CPHA, bit order, SCLK divider and one-hot
// active-low chip selects. Transfer runs IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
module spi_master_multi
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_CS = 4,
  parameter int unsigned DIV_W  = 8,
  localparam int unsigned SelW  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk_i,
  input  logic              aresetn_i,
  input  logic              load_i,
  input  logic              start_i,
  input  logic              read_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  input  logic [SelW-1:0]   cs_sel_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              lsb_first_i,
  input  logic [DIV_W-1:0]  clk_div_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rx_valid_o,
  input  logic              miso_i,
  output logic              sclk_o,
  output logic              mosi_o,
  output logic [NUM_CS-1:0] cs_o
);

  localparam int unsigned    EdgeW    = $clog2(2 * DATA_W + 1);
  localparam logic [EdgeW-1:0] LastEdge = EdgeW'(2 * DATA_W);
  localparam logic [SelW:0]  NumCsW   = (SelW + 1)'(NUM_CS);

  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w,
                                                   input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  spi_state_e        state_q, state_d;
  spi_mode_t         mode_q, mode_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [SelW-1:0]   sel_q, sel_d;
  logic [DATA_W-1:0] tx_q, tx_d, sh_q, sh_d, rx_q, rx_d, data_q, data_d;
  logic [EdgeW-1:0]  edge_q, edge_d;
  logic              mosi_q, mosi_d, done_q, done_d, rx_valid_q, rx_valid_d;

  logic accept, sel_ok, toggle, tick, lead_stb, trail_stb, gen_sclk, clk_cpol;
  logic sample_stb, drive_stb;

  assign sel_ok   = ({1'b0, cs_sel_i} < NumCsW);
  assign accept   = (state_q == StIdle) && start_i && sel_ok;
  assign toggle   = (state_q == StSetup) || ((state_q == StShift) && (edge_q < LastEdge));
  // The mode register is only valid from the cycle after acceptance.
  assign clk_cpol = accept ? cpol_i : mode_q.cpol;

  spi_clk_gen #(
    .DIV_W (DIV_W)
  ) u_clk_gen (
    .clk_i       (clk_i),
    .aresetn_i   (aresetn_i),
    .start_i     (accept),
    .run_i       (state_q != StIdle),
    .toggle_i    (toggle),
    .div_i       (div_q),
    .cpol_i      (clk_cpol),
    .tick_o      (tick),
    .lead_stb_o  (lead_stb),
    .trail_stb_o (trail_stb),
    .sclk_o      (gen_sclk)
  );

  assign sample_stb = mode_q.cpha ? trail_stb : lead_stb;
  assign drive_stb  = mode_q.cpha ? lead_stb : trail_stb;

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StSetup;
      StSetup: if (tick) state_d = StShift;
      StShift: if (tick && (edge_q == LastEdge)) state_d = StHold;
      StHold:  if (tick) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o = (state_q != StIdle);
    sclk_o = busy_o ? gen_sclk : cpol_i;
    cs_o   = '1;
    if (busy_o) cs_o[sel_q] = 1'b0;
  end

  always_comb begin
    tx_d       = ((state_q == StIdle) && load_i) ? data_i : tx_q;
    mode_d     = mode_q;
    div_d      = div_q;
    sel_d      = sel_q;
    sh_d       = sh_q;
    rx_d       = rx_q;
    mosi_d     = mosi_q;
    edge_d     = edge_q;
    data_d     = data_q;
    done_d     = 1'b0;
    // A read in the done cycle loses to the fresh word.
    rx_valid_d = (read_i && !done_q) ? 1'b0 : rx_valid_q;
    if (accept) begin
      mode_d = '{cpol: cpol_i, cpha: cpha_i, lsb_first: lsb_first_i};
      div_d  = clk_div_i;
      sel_d  = cs_sel_i;
      edge_d = '0;
      sh_d   = tx_d;
      if (!cpha_i) begin
        mosi_d = first_bit(tx_d, lsb_first_i);
        sh_d   = shift_word(tx_d, lsb_first_i);
      end
    end
    if (tick && toggle) edge_d = edge_q + EdgeW'(1);
    if (drive_stb) begin
      mosi_d = first_bit(sh_q, mode_q.lsb_first);
      sh_d   = shift_word(sh_q, mode_q.lsb_first);
    end
    if (sample_stb) begin
      rx_d = mode_q.lsb_first ? {miso_i, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], miso_i};
    end
    if ((state_q == StHold) && tick) begin
      done_d     = 1'b1;
      data_d     = rx_q;
      rx_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      mode_q     <= '0;
      div_q      <= '0;
      sel_q      <= '0;
      tx_q       <= '0;
      sh_q       <= '0;
      rx_q       <= '0;
      data_q     <= '0;
      edge_q     <= '0;
      mosi_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      div_q      <= div_d;
      sel_q      <= sel_d;
      tx_q       <= tx_d;
      sh_q       <= sh_d;
      rx_q       <= rx_d;
      data_q     <= data_d;
      edge_q     <= edge_d;
      mosi_q     <= mosi_d;
      done_q     <= done_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign data_o     = data_q;
  assign done_o     = done_q;
  assign rx_valid_o = rx_valid_q;
  assign mosi_o     = mosi_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi with a behavioural SPI slave (or mosi loopback).
module tb_spi_master_multi;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned NUM_CS = 3;
  localparam int unsigned DIV_W  = 8;

  logic              clk_i, aresetn_i, load_i, start_i, read_i;
  logic [DATA_W-1:0] data_i, data_o;
  logic [1:0]        cs_sel_i;
  logic              cpol_i, cpha_i, lsb_first_i;
  logic [DIV_W-1:0]  clk_div_i;
  logic              busy_o, done_o, rx_valid_o, miso_i, sclk_o, mosi_o;
  logic [NUM_CS-1:0] cs_o;

  int tests = 0;
  int fails = 0;

  spi_master_multi #(
    .DATA_W (DATA_W),
    .NUM_CS (NUM_CS),
    .DIV_W  (DIV_W)
  ) dut (
    .clk_i       (clk_i),
    .aresetn_i   (aresetn_i),
    .load_i      (load_i),
    .start_i     (start_i),
    .read_i      (read_i),
    .data_i      (data_i),
    .data_o      (data_o),
    .cs_sel_i    (cs_sel_i),
    .cpol_i      (cpol_i),
    .cpha_i      (cpha_i),
    .lsb_first_i (lsb_first_i),
    .clk_div_i   (clk_div_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rx_valid_o  (rx_valid_o),
    .miso_i      (miso_i),
    .sclk_o      (sclk_o),
    .mosi_o      (mosi_o),
    .cs_o        (cs_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Slave model: counts SCLK edges while selected and presents the matching bit.
  logic       loopback;
  logic [7:0] slave_word;
  logic       s_prev, cs_was_low;
  int         s_edges, s_idx, rises;

  initial begin
    s_prev = 1'b0; cs_was_low = 1'b0; s_edges = 0; s_idx = 0; rises = 0; miso_i = 1'b0;
  end

  always @(negedge clk_i) begin
    if (cs_o == '1) begin
      s_edges    = 0;
      cs_was_low = 1'b0;
    end else begin
      if (!cs_was_low) rises = 0;
      cs_was_low = 1'b1;
      if (sclk_o != s_prev) s_edges++;
      if (sclk_o && !s_prev) rises++;
    end
    s_prev = sclk_o;
    if (cpha_i) s_idx = (s_edges == 0) ? 0 : (s_edges + 1) / 2 - 1;
    else        s_idx = s_edges / 2;
    if (s_idx > 7) s_idx = 7;
    miso_i = loopback ? mosi_o : (lsb_first_i ? slave_word[s_idx] : slave_word[7 - s_idx]);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns the cycle index (relative to the start cycle) of done_o, or -1 on timeout.
  task automatic wait_done(input int start_cnt, output int cyc);
    cyc = start_cnt;
    while (cyc < 400) begin
      @(negedge clk_i);
      cyc++;
      if (done_o) return;
    end
    cyc = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  int cyc, ndone;

  initial begin
    aresetn_i = 1'b0; load_i = 1'b0; start_i = 1'b0; read_i = 1'b0; data_i = '0;
    cs_sel_i = '0; cpol_i = 1'b0; cpha_i = 1'b0; lsb_first_i = 1'b0; clk_div_i = '0;
    loopback = 1'b1; slave_word = '0;
    repeat (2) @(negedge clk_i);
    check("rst data_o",   32'(data_o),     32'h0);
    check("rst busy_o",   32'(busy_o),     32'h0);
    check("rst done_o",   32'(done_o),     32'h0);
    check("rst rx_valid", 32'(rx_valid_o), 32'h0);
    check("rst sclk_o",   32'(sclk_o),     32'h0);
    check("rst mosi_o",   32'(mosi_o),     32'h0);
    check("rst cs_o",     32'(cs_o),       32'h7);
    aresetn_i = 1'b1;
    @(negedge clk_i);

    // Mode 0, div 0, load+start together, loopback.
    data_i = 8'hA5; load_i = 1'b1; start_i = 1'b1;
    @(negedge clk_i);
    load_i = 1'b0; start_i = 1'b0;
    check("m0 busy k+1", 32'(busy_o), 32'h1);
    check("m0 cs k+1",   32'(cs_o),   32'h6);
    check("m0 mosi k+1", 32'(mosi_o), 32'h1);
    wait_done(1, cyc);
    check("m0 done latency", 32'(cyc),        32'd19);
    check("m0 data_o",       32'(data_o),     32'hA5);
    check("m0 rx_valid",     32'(rx_valid_o), 32'h1);
    check("m0 sclk rises",   32'(rises),      32'd8);
    check("m0 cs released",  32'(cs_o),       32'h7);

    // All four modes, div 3, slave returns 0x3C.
    loopback = 1'b0; slave_word = 8'h3C; clk_div_i = 8'd3;
    for (int m = 0; m < 4; m++) begin
      cpol_i = m[1]; cpha_i = m[0];
      @(negedge clk_i);
      check($sformatf("mode%0d sclk idle before", m), 32'(sclk_o), 32'(m[1]));
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      wait_done(1, cyc);
      check($sformatf("mode%0d latency", m),          32'(cyc),    32'd73);
      check($sformatf("mode%0d data_o", m),           32'(data_o), 32'h3C);
      check($sformatf("mode%0d sclk idle after", m),  32'(sclk_o), 32'(m[1]));
    end

    // LSB-first, TX 0x01, slave 0x80.
    cpol_i = 1'b0; cpha_i = 1'b0; clk_div_i = 8'd0; lsb_first_i = 1'b1; slave_word = 8'h80;
    data_i = 8'h01; load_i = 1'b1;
    @(negedge clk_i);
    load_i = 1'b0; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    check("lsb first mosi", 32'(mosi_o), 32'h1);
    wait_done(1, cyc);
    check("lsb data_o", 32'(data_o), 32'h80);

    // Slave 2, with load/start mid-transfer, then read handshake.
    lsb_first_i = 1'b0; cs_sel_i = 2'd2; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    check("sel2 cs_o", 32'(cs_o), 32'h3);
    repeat (5) @(negedge clk_i);
    data_i = 8'hFF; load_i = 1'b1; start_i = 1'b1;
    @(negedge clk_i);
    load_i = 1'b0; start_i = 1'b0;
    check("mid busy", 32'(busy_o), 32'h1);
    wait_done(7, cyc);
    check("mid start ignored latency", 32'(cyc), 32'd19);
    read_i = 1'b1;
    @(negedge clk_i);
    check("read with done rx_valid", 32'(rx_valid_o), 32'h1);
    check("no restart busy",         32'(busy_o),     32'h0);
    @(negedge clk_i);
    read_i = 1'b0;
    check("read clears rx_valid", 32'(rx_valid_o), 32'h0);

    // TX register must still hold 0x01 after the ignored mid-transfer load.
    loopback = 1'b1; cs_sel_i = 2'd0; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done(1, cyc);
    check("tx unchanged data_o", 32'(data_o), 32'h01);

    // Out-of-range slave index is ignored.
    cs_sel_i = 2'd3; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    check("bad sel busy", 32'(busy_o), 32'h0);
    check("bad sel cs",   32'(cs_o),   32'h7);
    ndone = 0;
    repeat (30) begin
      @(negedge clk_i);
      if (done_o) ndone++;
    end
    check("bad sel no done", 32'(ndone), 32'd0);

    // Asynchronous reset in the middle of SHIFT.
    cs_sel_i = 2'd1; clk_div_i = 8'd3; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (19) @(negedge clk_i);
    check("pre-reset busy", 32'(busy_o), 32'h1);
    #2 aresetn_i = 1'b0;
    #1;
    check("async rst cs_o",     32'(cs_o),       32'h7);
    check("async rst sclk_o",   32'(sclk_o),     32'h0);
    check("async rst busy_o",   32'(busy_o),     32'h0);
    check("async rst data_o",   32'(data_o),     32'h0);
    check("async rst rx_valid", 32'(rx_valid_o), 32'h0);
    check("async rst mosi_o",   32'(mosi_o),     32'h0);
    @(negedge clk_i);
    aresetn_i = 1'b1;
    @(negedge clk_i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_master_multi.md
# spi_master_multi

Parametrised SPI master, successor to the fixed 8-bit, single-slave, mode-0 master. It adds configurable word width, all four CPOL/CPHA modes, an MSB/LSB-first option, a programmable SCLK divider and multiple one-hot chip selects. It sits between the register/CPU side (load/start/read strobes) and the SPI pins.

## Interface
- DATA_W, 8, bits per transfer (≥2)
- NUM_CS, 4, number of chip-select lines (≥1)
- DIV_W, 8, width of clock-divider input
- clk_i  in  1  system clock; all logic on rising edge
- aresetn_i  in  1  asynchronous, active-low reset
- load_i  in  1  capture data_i into TX register (idle only)
- start_i  in  1  begin transfer (idle only)
- read_i  in  1  acknowledge RX data, clears rx_valid_o
- data_i  in  DATA_W  TX word
- data_o  out  DATA_W  last received word
- cs_sel_i  in  $clog2(NUM_CS) (min 1)  slave index, sampled at start
- cpol_i, cpha_i, lsb_first_i  in  1 each  mode, sampled at start
- clk_div_i  in  DIV_W  SCLK half-period = clk_div_i+1 clk cycles, sampled at start
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle pulse at transfer end
- rx_valid_o  out  1  data_o holds unread word
- miso_i  in  1  serial in
- sclk_o  out  1  serial clock
- mosi_o  out  1  serial out
- cs_o  out  NUM_CS  chip selects, active low

## Operation
- Reset values: data_o=0, busy_o=0, done_o=0, rx_valid_o=0, sclk_o=0, mosi_o=0, cs_o=all ones, TX register=0.
- FSM: IDLE → SETUP → SHIFT → HOLD → IDLE.
- IDLE: sclk_o = cpol_i (live). load_i writes TX register. start_i with cs_sel_i < NUM_CS latches mode/div/sel, enters SETUP; start_i with cs_sel_i ≥ NUM_CS is ignored (no done_o).
- SETUP: selected cs_o bit low, sclk_o = latched CPOL; for CPHA=0, first bit on mosi_o. Lasts H = div+1 cycles.
- SHIFT: 2·DATA_W SCLK edges, each H cycles apart. CPHA=0: sample miso_i on leading edge, drive next bit on trailing edge. CPHA=1: drive on leading, sample on trailing. Bit order MSB-first unless lsb_first latched high; RX assembled in the same order.
- HOLD: sclk_o idle, CS still low, H cycles. Then IDLE: cs_o all ones, data_o ← RX shift register, done_o=1 for one cycle, rx_valid_o=1.
- load_i/start_i while busy_o=1 are ignored; TX register unchanged.
- read_i clears rx_valid_o; done_o and read_i in the same cycle → rx_valid_o stays 1.
- New transfer overwrites data_o regardless of rx_valid_o (no overflow flag).
- load_i and start_i same cycle in IDLE: transfer sends the new data_i.
- Reset mid-transfer: all outputs return to reset values asynchronously; CS released immediately.

## Timing
- start_i sampled at edge k: busy_o and CS low from k+1; CS low for (2·DATA_W+2)·H cycles; done_o and CS release at k+(2·DATA_W+2)·H+1.
- DATA_W=8, div=0: CS low 18 cycles, done_o at k+19.
- First leading SCLK edge at k+1+H; edges every H cycles thereafter.
- Back-to-back: start_i accepted in the done_o cycle.

## Structure
- Package spi_pkg: state enum (IDLE, SETUP, SHIFT, HOLD), spi_mode_t struct {cpol, cpha, lsb_first}.
- Sub-module spi_clk_gen: divider counter, emits lead_stb/trail_stb strobes and sclk level from latched div and CPOL; FSM and shift registers stay in top.

## Test plan
- Mode 0, DATA_W=8, div=0, TX 0xA5, miso loopback from mosi → data_o=0xA5, done_o at k+19, 8 rising edges on sclk_o.
- All four modes, div=3, slave model returns 0x3C → data_o=0x3C each mode; sclk idle level = CPOL before/after.
- lsb_first=1, TX 0x01 → first mosi bit 1; slave sends 0x80 LSB-first → data_o=0x80 (bit7 last).
- cs_sel_i=2 → only cs_o[2] low; cs_sel_i=NUM_CS → no transfer, busy_o stays 0.
- start_i/load_i mid-transfer ignored; read_i coincident with done_o → rx_valid_o=1; next-cycle read_i → 0.
- aresetn_i low mid-SHIFT → cs_o=all ones, sclk_o=0, busy_o=0 without waiting for clk edge.
